// File: rtl/dff_ctrl_pkg.sv
// Shared control definitions for the register-bank arbiters.
//  - ST_IDLE / ST_GRANT state encodings and the matching state_e enum.
//  - rr_pick: masked round-robin search over up to MaxReq request lanes.
package dff_ctrl_pkg;

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_GRANT = 1'b1;

  typedef enum logic {
    StIdle  = ST_IDLE,
    StGrant = ST_GRANT
  } state_e;

  // Callers zero-extend their request vectors to this width.
  localparam int unsigned MaxReq = 32;
  localparam int unsigned IdxW   = 5;

  typedef struct packed {
    logic            found;
    logic [IdxW-1:0] idx;
  } rr_pick_t;

  // First set bit of (req & ~mask), searching upward from ptr and wrapping at nreq.
  // ptr must be < nreq.
  function automatic rr_pick_t rr_pick(input logic [MaxReq-1:0] req,
                                       input logic [MaxReq-1:0] mask,
                                       input logic [IdxW-1:0]   ptr,
                                       input int                nreq);
    rr_pick_t          res;
    logic [MaxReq-1:0] live;
    int                idx;
    logic [IdxW-1:0]   sel;
    res  = '0;
    live = req & ~mask;
    // Walk from the farthest distance down so the nearest hit wins.
    for (int k = MaxReq - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= nreq) idx = idx - nreq;
      sel = IdxW'(idx);
      if (k < nreq && live[sel]) begin
        res.found = 1'b1;
        res.idx   = sel;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/dff_bank.sv
// WIDTH-bit storage register with synchronous load enable.
//  clk_i  : rising-edge clock
//  rst_ni : asynchronous active-low reset, clears the register
//  en_i   : load d_i at the next rising edge
//  d_i    : load data
//  q_o    : register contents
module dff_bank #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] q_d, q_q;

  always_comb begin
    q_d = q_q;
    if (en_i) q_d = d_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) q_q <= '0;
    else         q_q <= q_d;
  end

  assign q_o = q_q;

endmodule

// File: rtl/dff_bank_arbiter.sv
// Round-robin arbiter sharing one WIDTH-bit register among NREQ requesters, with an
// optional locked burst of up to MAX_BURST consecutive writes per grant.
//  clk      : rising-edge clock
//  rst      : asynchronous active-low reset
//  req      : per-requester write request (level)
//  lock     : per-requester burst hold, only meaningful with req
//  wdata    : flat write data, requester i at [i*WIDTH +: WIDTH]
//  gnt      : registered one-hot grant
//  owner    : index of the current / last grantee
//  busy     : high while a grant is active
//  wr_pulse : high for one cycle after q was loaded
//  q        : shared register contents
module dff_bank_arbiter
  import dff_ctrl_pkg::*;
#(
  parameter int unsigned NREQ      = 4,
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ-1:0]         lock,
  input  logic [NREQ*WIDTH-1:0]   wdata,
  output logic [NREQ-1:0]         gnt,
  output logic [$clog2(NREQ)-1:0] owner,
  output logic                    busy,
  output logic                    wr_pulse,
  output logic [WIDTH-1:0]        q
);

  localparam int unsigned OwnerW = $clog2(NREQ);
  localparam int unsigned CntW   = $clog2(MAX_BURST + 1);
  // Last burst count at which another locked write is still allowed to follow.
  localparam logic [CntW-1:0] CntLast = CntW'(MAX_BURST - 1);

  state_e            state_d, state_q;
  logic [NREQ-1:0]   gnt_d, gnt_q;
  logic [OwnerW-1:0] owner_d, owner_q;
  logic [OwnerW-1:0] rr_ptr_d, rr_ptr_q;
  logic [CntW-1:0]   burst_cnt_d, burst_cnt_q;
  logic              wr_pulse_d, wr_pulse_q;

  logic              wr_en;
  logic [OwnerW-1:0] next_ptr;
  rr_pick_t          idle_pick, rel_pick;
  logic [WIDTH-1:0]  wdata_arr [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign wdata_arr[i] = wdata[i*WIDTH +: WIDTH];
  end

  assign next_ptr = (owner_q == OwnerW'(NREQ - 1)) ? '0 : owner_q + OwnerW'(1);

  // Idle arbitration starts at rr_ptr; release arbitration starts after the owner and
  // excludes it, so a requester still holding req re-joins behind the others.
  assign idle_pick = rr_pick(MaxReq'(req), '0, IdxW'(rr_ptr_q), NREQ);
  assign rel_pick  = rr_pick(MaxReq'(req), MaxReq'(gnt_q), IdxW'(next_ptr), NREQ);

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    burst_cnt_d = burst_cnt_q;
    wr_en       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (|req) begin
          state_d     = StGrant;
          owner_d     = OwnerW'(idle_pick.idx);
          gnt_d       = NREQ'(1) << idle_pick.idx;
          burst_cnt_d = '0;
        end
      end
      StGrant: begin
        // A withdrawn request means no write this cycle.
        wr_en = req[owner_q];
        if (wr_en) burst_cnt_d = burst_cnt_q + CntW'(1);
        if (!(wr_en && lock[owner_q] && burst_cnt_q < CntLast)) begin
          rr_ptr_d    = next_ptr;
          burst_cnt_d = '0;
          if (rel_pick.found) begin
            owner_d = OwnerW'(rel_pick.idx);
            gnt_d   = NREQ'(1) << rel_pick.idx;
          end else begin
            state_d = StIdle;
            gnt_d   = '0;
          end
        end
      end
      default: begin
        state_d = StIdle;
        gnt_d   = '0;
      end
    endcase
    wr_pulse_d = wr_en;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      gnt_q       <= '0;
      owner_q     <= '0;
      rr_ptr_q    <= '0;
      burst_cnt_q <= '0;
      wr_pulse_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      burst_cnt_q <= burst_cnt_d;
      wr_pulse_q  <= wr_pulse_d;
    end
  end

  dff_bank #(
    .WIDTH(WIDTH)
  ) u_bank (
    .clk_i (clk),
    .rst_ni(rst),
    .en_i  (wr_en),
    .d_i   (wdata_arr[owner_q]),
    .q_o   (q)
  );

  assign gnt      = gnt_q;
  assign owner    = owner_q;
  assign busy     = (state_q == StGrant);
  assign wr_pulse = wr_pulse_q;

endmodule

// File: tb/tb_dff_bank_arbiter.sv
module tb_dff_bank_arbiter;

  localparam int NREQ      = 4;
  localparam int WIDTH     = 8;
  localparam int MAX_BURST = 4;

  logic                    clk;
  logic                    rst;
  logic [NREQ-1:0]         req;
  logic [NREQ-1:0]         lock;
  logic [NREQ*WIDTH-1:0]   wdata;
  logic [NREQ-1:0]         gnt;
  logic [$clog2(NREQ)-1:0] owner;
  logic                    busy;
  logic                    wr_pulse;
  logic [WIDTH-1:0]        q;

  dff_bank_arbiter #(
    .NREQ     (NREQ),
    .WIDTH    (WIDTH),
    .MAX_BURST(MAX_BURST)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .lock    (lock),
    .wdata   (wdata),
    .gnt     (gnt),
    .owner   (owner),
    .busy    (busy),
    .wr_pulse(wr_pulse),
    .q       (q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  // Behavioural model: who holds the register, how many writes it has made, where the
  // next search begins, and what the register holds.
  bit         m_active;
  int         m_owner;
  int         m_writes;
  int         m_start;
  logic [7:0] m_q;
  bit         m_wp;

  function automatic int first_from(input logic [3:0] r, input int start, input int skip);
    int hit;
    hit = -1;
    for (int k = NREQ - 1; k >= 0; k--) begin
      int i;
      i = (start + k) % NREQ;
      if (r[i] && i != skip) hit = i;
    end
    return hit;
  endfunction

  task automatic model_reset();
    m_active = 0; m_owner = 0; m_writes = 0; m_start = 0; m_q = '0; m_wp = 0;
  endtask

  task automatic model_step(input logic [3:0] r, input logic [3:0] l, input logic [31:0] wd);
    int w;
    bit wrote;
    m_wp = 0;
    if (!m_active) begin
      w = first_from(r, m_start, -1);
      if (w >= 0) begin
        m_active = 1; m_owner = w; m_writes = 0;
      end
    end else begin
      wrote = r[m_owner];
      if (wrote) begin
        m_q = wd[m_owner*8 +: 8];
        m_wp = 1;
        m_writes++;
      end
      if (!(wrote && l[m_owner] && m_writes < MAX_BURST)) begin
        m_start = (m_owner + 1) % NREQ;
        w = first_from(r, m_start, m_owner);
        if (w >= 0) begin
          m_owner = w; m_writes = 0;
        end else begin
          m_active = 0;
        end
      end
    end
  endtask

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    logic [3:0] eg;
    eg = m_active ? 4'(1 << m_owner) : 4'b0000;
    check("gnt", 32'(gnt), 32'(eg));
    check("owner", 32'(owner), 32'(m_owner));
    check("busy", 32'(busy), 32'(m_active));
    check("wr_pulse", 32'(wr_pulse), 32'(m_wp));
    check("q", 32'(q), 32'(m_q));
  end

  task automatic cycle(input logic [3:0] r, input logic [3:0] l, input logic [31:0] wd);
    req = r; lock = l; wdata = wd;
    @(posedge clk);
    if (rst) model_step(r, l, wd);
    else     model_reset();
    #1;
  endtask

  function automatic logic [31:0] pack(input logic [7:0] d0, input logic [7:0] d1,
                                       input logic [7:0] d2, input logic [7:0] d3);
    return {d3, d2, d1, d0};
  endfunction

  logic [31:0] wd;

  initial begin
    rst = 1'b0; req = '0; lock = '0; wdata = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset gnt", 32'(gnt), 32'h0);
    check("reset q", 32'(q), 32'h0);
    check("reset busy", 32'(busy), 32'h0);
    rst = 1'b1;

    // Round robin with all four requesting.
    wd = pack(8'hAA, 8'hBB, 8'hA5, 8'hDD);
    cycle(4'b1111, 4'b0000, wd);
    check("rr first gnt", 32'(gnt), 32'h1);
    cycle(4'b1111, 4'b0000, wd);
    check("rr q0", 32'(q), 32'hAA);
    check("rr gnt1", 32'(gnt), 32'h2);
    cycle(4'b1111, 4'b0000, wd);
    cycle(4'b1111, 4'b0000, wd);
    check("rr q2", 32'(q), 32'hA5);
    check("rr gnt3", 32'(gnt), 32'h8);
    cycle(4'b1111, 4'b0000, wd);
    check("rr q3", 32'(q), 32'hDD);
    check("rr wrap gnt0", 32'(gnt), 32'h1);
    cycle(4'b1111, 4'b0000, wd);
    check("rr q0 again", 32'(q), 32'hAA);
    cycle(4'b0000, 4'b0000, wd);
    check("rr drop idle", 32'(busy), 32'h0);
    check("rr drop q", 32'(q), 32'hAA);

    // Single request from requester 2.
    cycle(4'b0100, 4'b0000, wd);
    check("single gnt", 32'(gnt), 32'h4);
    check("single owner", 32'(owner), 32'h2);
    cycle(4'b0100, 4'b0000, wd);
    check("single q", 32'(q), 32'hA5);
    check("single wr_pulse", 32'(wr_pulse), 32'h1);
    check("single idle", 32'(busy), 32'h0);
    cycle(4'b0000, 4'b0000, wd);
    check("owner holds", 32'(owner), 32'h2);

    // Owner 3 releases: search wraps to 0 ahead of 1.
    cycle(4'b1011, 4'b0000, wd);
    check("wrap owner3", 32'(owner), 32'h3);
    cycle(4'b1011, 4'b0000, wd);
    check("wrap q", 32'(q), 32'hDD);
    check("wrap owner0", 32'(owner), 32'h0);
    cycle(4'b0000, 4'b0000, wd);

    // Withdrawal by requester 3; locks on idle lanes are ignored.
    cycle(4'b1000, 4'b0111, wd);
    check("wd gnt", 32'(gnt), 32'h8);
    cycle(4'b0000, 4'b0111, wd);
    check("wd no pulse", 32'(wr_pulse), 32'h0);
    check("wd q held", 32'(q), 32'hDD);
    check("wd idle", 32'(busy), 32'h0);

    // Locked burst capped at MAX_BURST writes.
    cycle(4'b0011, 4'b0001, wd);
    check("burst gnt0", 32'(gnt), 32'h1);
    for (int k = 0; k < 4; k++) begin
      cycle(4'b0011, 4'b0001, pack(8'(8'h10 + k), 8'hB1, 8'hA5, 8'hDD));
      check("burst q", 32'(q), 32'(8'h10 + k));
      check("burst gnt", 32'(gnt), (k < 3) ? 32'h1 : 32'h2);
    end
    cycle(4'b0011, 4'b0001, pack(8'h14, 8'hB1, 8'hA5, 8'hDD));
    check("after burst q", 32'(q), 32'hB1);
    check("after burst gnt", 32'(gnt), 32'h1);
    cycle(4'b0000, 4'b0000, wd);

    // Reset in the middle of a locked burst.
    cycle(4'b0001, 4'b0001, pack(8'hC0, 8'h0, 8'h0, 8'h0));
    cycle(4'b0001, 4'b0001, pack(8'hC1, 8'h0, 8'h0, 8'h0));
    check("pre-reset q", 32'(q), 32'hC1);
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    check("async gnt", 32'(gnt), 32'h0);
    check("async q", 32'(q), 32'h0);
    check("async busy", 32'(busy), 32'h0);
    check("async wr_pulse", 32'(wr_pulse), 32'h0);
    cycle(4'b0001, 4'b0001, wd);
    cycle(4'b0001, 4'b0001, wd);
    check("held reset q", 32'(q), 32'h0);
    rst = 1'b1;
    cycle(4'b0011, 4'b0000, wd);
    check("ptr cleared owner", 32'(owner), 32'h0);
    cycle(4'b0011, 4'b0000, wd);
    check("post-reset q", 32'(q), 32'hAA);
    check("post-reset owner", 32'(owner), 32'h1);
    cycle(4'b0000, 4'b0000, wd);
    cycle(4'b0000, 4'b0000, wd);

    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
